// File: rtl/clkdiv_pkg.sv
// Shared types and default constants for the clock divider controller.
package clkdiv_pkg;

   localparam int CNT_W       = 16;
   localparam int DEFAULT_DIV = 25;

   typedef enum logic [1:0] {
      STOP = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

endpackage

// File: rtl/clkdiv_core.sv
// Period counter for the clock divider: wrap compare, registered tick and clk_out.
// Expects div_eff >= 1; dropping run clears the counter and both outputs on the next edge.
module clkdiv_core #(
   parameter int CNT_W = clkdiv_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic [CNT_W-1:0] div_eff,
   output logic             tick,
   output logic             clk_out,
   output logic             wrap
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_last;
   logic [CNT_W-1:0] cnt_half;

   assign cnt_last = div_eff - CNT_ONE;
   assign cnt_half = div_eff >> 1;
   assign wrap     = run && (cnt_q == cnt_last);

   always_ff @(posedge clk) begin
      if (reset || !run) begin
         cnt_q   <= '0;
         tick    <= 1'b0;
         clk_out <= 1'b0;
      end else begin
         cnt_q   <= wrap ? '0 : cnt_q + CNT_ONE;
         tick    <= wrap;
         clk_out <= (cnt_q >= cnt_half);
      end
   end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Clock divider controller: run FSM, divisor handshake and sticky period interrupt.
// Define CLKDIV_CTRL_IRQ_EN to build the irq logic; otherwise irq is tied low.
//
//   state | meaning
//   STOP  | idle, counter cleared, divisor loads take effect immediately
//   RUN   | dividing, ready to accept a new divisor
//   PEND  | dividing, accepted divisor waits for the next wrap
module clkdiv_ctrl #(
   parameter int CNT_W       = clkdiv_pkg::CNT_W,
   parameter int DEFAULT_DIV = clkdiv_pkg::DEFAULT_DIV
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [CNT_W-1:0] div_in,
   input  logic             div_valid,
   output logic             div_ready,
   output logic [CNT_W-1:0] div_cur,
   output logic             tick,
   output logic             clk_out,
   output logic             irq,
   input  logic             irq_ack
);

   import clkdiv_pkg::*;

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] pend_q;
   logic [CNT_W-1:0] div_eff;
   logic             hs;
   logic             run;
   logic             wrap;

   assign hs      = div_valid && div_ready;
   // A stored divisor of 0 divides by 1
   assign div_eff = (div_cur == '0) ? CNT_W'(1) : div_cur;
   assign run     = (state_q != STOP) && en;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= STOP;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         STOP: if (en) state_d = RUN;
         RUN: begin
            if (!en)     state_d = STOP;
            else if (hs) state_d = PEND;
         end
         PEND: begin
            if (!en)       state_d = STOP;
            else if (wrap) state_d = RUN;
         end
         default: state_d = STOP;
      endcase
   end

   always_comb begin
      div_ready = 1'b1;
      if (state_q == PEND) div_ready = 1'b0;
   end

   // A load accepted on a wrap cycle is held for the following wrap
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cur <= CNT_W'(DEFAULT_DIV);
         pend_q  <= '0;
      end else begin
         unique case (state_q)
            STOP: if (hs) div_cur <= div_in;
            RUN: begin
               if (hs && !en)     div_cur <= div_in;
               else if (hs && en) pend_q  <= div_in;
            end
            PEND: if (!en || wrap) div_cur <= pend_q;
            default: ;
         endcase
      end
   end

   clkdiv_core #(.CNT_W(CNT_W)) u_core (
      .clk     (clk),
      .reset   (reset),
      .run     (run),
      .div_eff (div_eff),
      .tick    (tick),
      .clk_out (clk_out),
      .wrap    (wrap)
   );

`ifdef CLKDIV_CTRL_IRQ_EN
   logic irq_q;

   always_ff @(posedge clk) begin
      if (reset)        irq_q <= 1'b0;
      else if (tick)    irq_q <= 1'b1;
      else if (irq_ack) irq_q <= 1'b0;
   end

   assign irq = irq_q;
`else
   logic unused_irq_ack;

   assign unused_irq_ack = irq_ack;
   assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Directed self-checking bench for clkdiv_ctrl; irq expectations follow CLKDIV_CTRL_IRQ_EN.
module tb_clkdiv_ctrl;

   import clkdiv_pkg::*;

   localparam int W = 16;
`ifdef CLKDIV_CTRL_IRQ_EN
   localparam logic IRQ_ON = 1'b1;
`else
   localparam logic IRQ_ON = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         en;
   logic [W-1:0] div_in;
   logic         div_valid;
   logic         div_ready;
   logic [W-1:0] div_cur;
   logic         tick;
   logic         clk_out;
   logic         irq;
   logic         irq_ack;

   int checks = 0;
   int errors = 0;
   int n;
   int highs;
   int ticks;
   int last_k;
   logic lo12;
   logic hi13;

   clkdiv_ctrl #(.CNT_W(W), .DEFAULT_DIV(25)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .div_in    (div_in),
      .div_valid (div_valid),
      .div_ready (div_ready),
      .div_cur   (div_cur),
      .tick      (tick),
      .clk_out   (clk_out),
      .irq       (irq),
      .irq_ack   (irq_ack)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic first_tick(output int lat);
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (tick) begin
            lat = i;
            break;
         end
      end
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; div_in = '0; div_valid = 1'b0; irq_ack = 1'b0;
      step(); step();
      check("rst_div_cur", 32'(div_cur), 32'd25);
      check("rst_div_ready", 32'(div_ready), 32'd1);
      check("rst_tick", 32'(tick), 32'd0);
      check("rst_clk_out", 32'(clk_out), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_state", 32'(dut.state_q), 32'(STOP));

      // default divisor 25
      reset = 1'b0; en = 1'b1;
      first_tick(n);
      check("d25_first_tick", 32'(n), 32'd26);
      highs = 0; ticks = 0; last_k = 0; lo12 = 1'bx; hi13 = 1'bx;
      for (int k = 1; k <= 25; k++) begin
         step();
         if (clk_out) highs++;
         if (tick) begin ticks++; last_k = k; end
         if (k == 12) lo12 = clk_out;
         if (k == 13) hi13 = clk_out;
      end
      check("d25_high_cycles", 32'(highs), 32'd13);
      check("d25_tick_count", 32'(ticks), 32'd1);
      check("d25_period", 32'(last_k), 32'd25);
      check("d25_clk_lo_end", 32'(lo12), 32'd0);
      check("d25_clk_hi_start", 32'(hi13), 32'd1);

      en = 1'b0; step();
      check("stop_tick", 32'(tick), 32'd0);
      check("stop_clk_out", 32'(clk_out), 32'd0);
      check("stop_state", 32'(dut.state_q), 32'(STOP));

      // D=4 then load 6 mid-period
      div_in = 16'd4; div_valid = 1'b1; step(); div_valid = 1'b0;
      check("stop_load", 32'(div_cur), 32'd4);
      en = 1'b1; step();
      step(); step(); step();
      check("d4_no_tick_e4", 32'(tick), 32'd0);
      step();
      check("d4_tick_e5", 32'(tick), 32'd1);
      step();
      div_in = 16'd6; div_valid = 1'b1; step(); div_valid = 1'b0;
      check("pend_ready", 32'(div_ready), 32'd0);
      check("pend_div_cur", 32'(div_cur), 32'd4);
      check("pend_state", 32'(dut.state_q), 32'(PEND));
      step();
      check("pend_no_tick_e8", 32'(tick), 32'd0);
      check("pend_div_cur_e8", 32'(div_cur), 32'd4);
      step();
      check("apply_tick_e9", 32'(tick), 32'd1);
      check("apply_div_cur", 32'(div_cur), 32'd6);
      check("apply_ready", 32'(div_ready), 32'd1);
      step(); step(); step(); step(); step();
      check("d6_no_tick_e14", 32'(tick), 32'd0);
      step();
      check("d6_tick_e15", 32'(tick), 32'd1);

      // handshake on the wrap cycle waits one more period
      step(); step(); step(); step(); step();
      div_in = 16'd3; div_valid = 1'b1; step(); div_valid = 1'b0;
      check("wraphs_tick", 32'(tick), 32'd1);
      check("wraphs_div_cur", 32'(div_cur), 32'd6);
      check("wraphs_state", 32'(dut.state_q), 32'(PEND));
      step(); step(); step(); step(); step();
      check("wraphs_no_tick", 32'(tick), 32'd0);
      check("wraphs_hold", 32'(div_cur), 32'd6);
      step();
      check("wraphs_tick2", 32'(tick), 32'd1);
      check("wraphs_apply", 32'(div_cur), 32'd3);

      // en drop while pending
      div_in = 16'd5; div_valid = 1'b1; step(); div_valid = 1'b0;
      check("drop_pre_state", 32'(dut.state_q), 32'(PEND));
      check("drop_pre_cnt", 32'(dut.u_core.cnt_q), 32'd1);
      en = 1'b0; step();
      check("drop_state", 32'(dut.state_q), 32'(STOP));
      check("drop_div_cur", 32'(div_cur), 32'd5);
      check("drop_clk_out", 32'(clk_out), 32'd0);
      check("drop_ready", 32'(div_ready), 32'd1);
      check("drop_tick", 32'(tick), 32'd0);

      // en low with a handshake in RUN applies directly
      en = 1'b1; step();
      en = 1'b0; div_in = 16'd7; div_valid = 1'b1; step(); div_valid = 1'b0;
      check("runstop_load", 32'(div_cur), 32'd7);
      check("runstop_state", 32'(dut.state_q), 32'(STOP));

      // divisor 0 behaves as 1
      div_in = 16'd0; div_valid = 1'b1; step(); div_valid = 1'b0;
      check("zero_div_cur", 32'(div_cur), 32'd0);
      en = 1'b1; step();
      step();
      check("zero_tick_e2", 32'(tick), 32'd1);
      ticks = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         if (tick) ticks++;
      end
      check("zero_tick_cont", 32'(ticks), 32'd4);
      check("zero_clk_out", 32'(clk_out), 32'd1);
      check("zero_irq", 32'(irq), 32'(IRQ_ON));

      // irq set/ack priority
      en = 1'b0; step();
      irq_ack = 1'b1; step(); irq_ack = 1'b0;
      check("irq_cleared", 32'(irq), 32'd0);
      div_in = 16'd4; div_valid = 1'b1; step(); div_valid = 1'b0;
      en = 1'b1; step();
      step(); step(); step(); step();
      check("irq_tick_e5", 32'(tick), 32'd1);
      irq_ack = 1'b1; step();
      check("irq_set_wins", 32'(irq), 32'(IRQ_ON));
      step(); irq_ack = 1'b0;
      check("irq_ack_clear", 32'(irq), 32'd0);

      // reset in PEND on the wrap cycle
      div_in = 16'd9; div_valid = 1'b1; step(); div_valid = 1'b0;
      check("rstpend_state", 32'(dut.state_q), 32'(PEND));
      check("rstpend_cnt", 32'(dut.u_core.cnt_q), 32'd3);
      reset = 1'b1; step();
      check("rstpend_tick", 32'(tick), 32'd0);
      check("rstpend_div_cur", 32'(div_cur), 32'd25);
      check("rstpend_fsm", 32'(dut.state_q), 32'(STOP));
      check("rstpend_ready", 32'(div_ready), 32'd1);
      check("rstpend_clk_out", 32'(clk_out), 32'd0);
      check("rstpend_irq", 32'(irq), 32'd0);
      reset = 1'b0; en = 1'b1;
      first_tick(n);
      check("rstpend_period", 32'(n), 32'd26);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
